// File: rtl/resp_frame_pkg.sv
// Package for the response-frame transmitter.
// Holds the frame constants, the transmit state encoding and the CRC-8 step
// function that the checksum accumulator uses when RESP_FRAME_CRC8_EN is defined.
package resp_frame_pkg;

    localparam logic [7:0] SOF0      = 8'hAA;
    localparam logic [7:0] SOF1      = 8'h55;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF0 = 3'd1,
        ST_SOF1 = 3'd2,
        ST_CMD  = 3'd3,
        ST_STAT = 3'd4,
        ST_LEN  = 3'd5,
        ST_PAY  = 3'd6,
        ST_CHK  = 3'd7
    } state_t;

    // One byte of MSB-first CRC-8 (init/xorout handled by the caller).
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/resp_chk_accum.sv
// Frame checksum accumulator.
// Build option: RESP_FRAME_CRC8_EN selects CRC-8 (poly 0x07, init 0x00);
// otherwise the checksum is the modulo-256 sum of the accumulated bytes.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the checksum at 0 (takes priority over enable)
//   enable    - fold data_in into the checksum this cycle
//   data_in   - byte to accumulate
//   chk_out   - current checksum value
module resp_chk_accum
    import resp_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic [7:0] chk_out
);

    logic [7:0] chk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk <= 8'h00;
        end else if (clear) begin
            chk <= 8'h00;
        end else if (enable) begin
`ifdef RESP_FRAME_CRC8_EN
            chk <= crc8_byte(chk, data_in);
`else
            chk <= chk + data_in;
`endif
        end
    end

    assign chk_out = chk;

endmodule

// File: rtl/resp_frame_tx.sv
// Response frame transmitter: serialises a posted response as
//   0xAA 0x55 CMD STATUS LEN P[0..LEN-1] CHK
// onto a valid/ready byte stream feeding the UART transmitter.
// Build option: RESP_FRAME_CRC8_EN switches CHK from a mod-256 sum to CRC-8.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   pl_wr_en/pl_wr_addr/pl_wr_data   - payload buffer write port (ignored while busy)
//   req_valid/req_ready              - response request handshake
//   req_cmd/req_status/req_len       - response fields, captured on accept
//   tx_data/tx_valid/tx_ready        - outgoing byte stream
//   busy                             - frame in progress
//   len_err                          - one-cycle pulse when req_len was clamped
//   frames_sent                      - completed frame counter (wraps)
module resp_frame_tx
    import resp_frame_pkg::*;
#(
    parameter int MAX_PAYLOAD = 16,
    parameter int AW          = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pl_wr_en,
    input  logic [AW-1:0] pl_wr_addr,
    input  logic [7:0]    pl_wr_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [7:0]    req_cmd,
    input  logic [7:0]    req_status,
    input  logic [7:0]    req_len,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          len_err,
    output logic [15:0]   frames_sent
);

    state_t      state, state_nxt;
    logic [7:0]  cmd_r, status_r, len_r;
    logic [7:0]  pay_idx;
    logic [7:0]  pl_mem [MAX_PAYLOAD];
    logic [7:0]  chk;
    logic        accept, hs, len_over, chk_en;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign tx_valid  = (state != ST_IDLE);
    assign accept    = req_valid & req_ready;
    assign hs        = tx_valid & tx_ready;
    assign len_over  = int'(req_len) > MAX_PAYLOAD;

    // The sync bytes and the checksum itself are excluded from the checksum.
    assign chk_en = hs && (state == ST_CMD || state == ST_STAT ||
                           state == ST_LEN || state == ST_PAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_data   = 8'h00;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_SOF0;
            ST_SOF0: begin
                tx_data = SOF0;
                if (hs) state_nxt = ST_SOF1;
            end
            ST_SOF1: begin
                tx_data = SOF1;
                if (hs) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                tx_data = cmd_r;
                if (hs) state_nxt = ST_STAT;
            end
            ST_STAT: begin
                tx_data = status_r;
                if (hs) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                tx_data = len_r;
                if (hs) state_nxt = (len_r == 8'd0) ? ST_CHK : ST_PAY;
            end
            ST_PAY: begin
                tx_data = pl_mem[pay_idx[AW-1:0]];
                if (hs && pay_idx == len_r - 8'd1) state_nxt = ST_CHK;
            end
            ST_CHK: begin
                tx_data = chk;
                if (hs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pay_idx     <= 8'd0;
            len_err     <= 1'b0;
            frames_sent <= 16'd0;
        end else begin
            len_err <= accept & len_over;
            if (accept)
                pay_idx <= 8'd0;
            else if (hs && state == ST_PAY)
                pay_idx <= pay_idx + 8'd1;
            if (hs && state == ST_CHK)
                frames_sent <= frames_sent + 16'd1;
        end
    end

    // Response fields are pure data; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_r    <= req_cmd;
            status_r <= req_status;
            len_r    <= len_over ? 8'(MAX_PAYLOAD) : req_len;
        end
    end

    // A write in the accept cycle still lands, since the frame only reads
    // the buffer several cycles later in PAY.
    always_ff @(posedge clk) begin
        if (pl_wr_en && state == ST_IDLE)
            pl_mem[pl_wr_addr] <= pl_wr_data;
    end

    resp_chk_accum u_chk (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (chk_en),
        .data_in (tx_data),
        .chk_out (chk)
    );

endmodule

// File: tb/tb_resp_frame_tx.sv
// Testbench for resp_frame_tx: randomized frames checked against a
// byte-list reference model of the frame format.
module tb_resp_frame_tx;

    localparam int MAXP = 16;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pl_wr_en;
    logic [AW-1:0] pl_wr_addr;
    logic [7:0]    pl_wr_data;
    logic          req_valid;
    logic          req_ready;
    logic [7:0]    req_cmd, req_status, req_len;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          len_err;
    logic [15:0]   frames_sent;

    int checks = 0;
    int errors = 0;
    logic [7:0]  mem [MAXP];
    logic [15:0] exp_frames = 16'd0;
    logic [7:0]  last_chk;

    always #5 clk = ~clk;

    resp_frame_tx #(.MAX_PAYLOAD(MAXP), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .pl_wr_en(pl_wr_en), .pl_wr_addr(pl_wr_addr), .pl_wr_data(pl_wr_data),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_status(req_status), .req_len(req_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .len_err(len_err), .frames_sent(frames_sent)
    );

    function automatic logic [7:0] model_chk(input logic [7:0] q[$]);
        logic [7:0] c = 8'h00;
        foreach (q[i]) begin
`ifdef RESP_FRAME_CRC8_EN
            logic [15:0] w;
            w = {c ^ q[i], 8'h00};
            for (int b = 15; b >= 8; b--)
                if (w[b]) w = w ^ (16'h0107 << (b - 8));
            c = w[7:0];
`else
            c = 8'((int'(c) + int'(q[i])) % 256);
`endif
        end
        return c;
    endfunction

    task automatic write_pl(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_wr_en = 1'b1; pl_wr_addr = a; pl_wr_data = d;
        @(negedge clk);
        pl_wr_en = 1'b0;
        mem[a] = d;
    endtask

    // rmode: 0 always ready, 1 toggling, 2 random. abort_at >= 0 asserts
    // reset when that many bytes have been handshaken.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] st, input logic [7:0] ln,
                             input int rmode, input bit wr_same, input bit spam, input int abort_at);
        logic [7:0] body[$];
        logic [7:0] expq[$];
        logic [7:0] eln;
        int k, cyc;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: req_ready=%b busy=%b, required 1/0", req_ready, busy);
        end
        req_valid = 1'b1; req_cmd = cmd; req_status = st; req_len = ln;
        tx_ready = 1'($urandom_range(0, 1));
        if (wr_same) begin
            pl_wr_en = 1'b1;
            pl_wr_addr = AW'($urandom_range(0, MAXP - 1));
            pl_wr_data = 8'($urandom);
            mem[pl_wr_addr] = pl_wr_data;
        end
        eln = (int'(ln) > MAXP) ? 8'(MAXP) : ln;
        body.push_back(cmd); body.push_back(st); body.push_back(eln);
        for (int i = 0; i < int'(eln); i++) body.push_back(mem[i]);
        expq = {8'hAA, 8'h55};
        foreach (body[i]) expq.push_back(body[i]);
        expq.push_back(model_chk(body));
        @(negedge clk);
        req_valid = 1'b0; pl_wr_en = 1'b0;
        k = 0; cyc = 0;
        while (k < expq.size() && cyc < 400) begin
            case (rmode)
                0: tx_ready = 1'b1;
                1: tx_ready = (cyc % 2 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc < 2) begin
                checks++;
                if (len_err !== (cyc == 0 && int'(ln) > MAXP)) begin
                    errors++;
                    $display("FAIL len_err cyc%0d: got %b, required %b", cyc, len_err, (cyc == 0 && int'(ln) > MAXP));
                end
            end
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== expq[k]) begin
                errors++;
                $display("FAIL byte%0d: got valid=%b data=%h, required 1 %h", k, tx_valid, tx_data, expq[k]);
            end
            if (k == expq.size() - 1) last_chk = tx_data;
            if (spam) begin
                pl_wr_en = 1'b1;
                pl_wr_addr = AW'($urandom_range(0, MAXP - 1));
                pl_wr_data = 8'($urandom);
            end
            if (abort_at >= 0 && k == abort_at) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if (tx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || frames_sent !== 16'd0) begin
                    errors++;
                    $display("FAIL abort: valid=%b busy=%b ready=%b frames=%0d, required 0 0 1 0",
                             tx_valid, busy, req_ready, frames_sent);
                end
                pl_wr_en = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                exp_frames = 16'd0;
                return;
            end
            @(posedge clk);
            if (tx_ready) k++;
            cyc++;
            @(negedge clk);
        end
        pl_wr_en = 1'b0; tx_ready = 1'b0;
        if (k < expq.size()) begin
            checks++; errors++;
            $display("FAIL timeout: %0d of %0d bytes sent", k, expq.size());
        end
        exp_frames++;
        checks++;
        if (frames_sent !== exp_frames || busy !== 1'b0 || req_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: frames=%0d busy=%b ready=%b valid=%b, required %0d 0 1 0",
                     frames_sent, busy, req_ready, tx_valid, exp_frames);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pl_wr_en = 1'b0; pl_wr_addr = '0; pl_wr_data = '0;
        req_valid = 1'b0; req_cmd = '0; req_status = '0; req_len = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
            len_err !== 1'b0 || frames_sent !== 16'd0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b data=%h busy=%b len_err=%b frames=%0d, required 1 0 00 0 0 0",
                     req_ready, tx_valid, tx_data, busy, len_err, frames_sent);
        end
        rst = 1'b0;
        for (int i = 0; i < MAXP; i++) write_pl(AW'(i), 8'($urandom));
    endtask

    task automatic test_empty_frame();
        run_frame(8'h01, 8'h00, 8'h00, 0, 1'b0, 1'b0, -1);
        checks++;
`ifdef RESP_FRAME_CRC8_EN
        if (last_chk !== 8'h6B) begin
            errors++; $display("FAIL crc_case1: got %h, required 6b", last_chk);
        end
`else
        if (last_chk !== 8'h01) begin
            errors++; $display("FAIL sum_case1: got %h, required 01", last_chk);
        end
`endif
    endtask

    task automatic test_payload();
        write_pl(4'd0, 8'h10);
        write_pl(4'd1, 8'h20);
        run_frame(8'h02, 8'h00, 8'h02, 0, 1'b0, 1'b0, -1);
`ifndef RESP_FRAME_CRC8_EN
        checks++;
        if (last_chk !== 8'h34) begin
            errors++; $display("FAIL sum_case2: got %h, required 34", last_chk);
        end
`endif
    endtask

    task automatic test_backpressure();
        run_frame(8'h02, 8'h00, 8'h02, 1, 1'b0, 1'b0, -1);
        run_frame(8'h33, 8'h07, 8'h05, 2, 1'b0, 1'b0, -1);
    endtask

    task automatic test_sum_wrap();
        run_frame(8'hFF, 8'h01, 8'h00, 0, 1'b0, 1'b0, -1);
`ifndef RESP_FRAME_CRC8_EN
        checks++;
        if (last_chk !== 8'h00) begin
            errors++; $display("FAIL sum_wrap: got %h, required 00", last_chk);
        end
`endif
    endtask

    task automatic test_len_clamp();
        run_frame(8'h44, 8'h00, 8'd20, 2, 1'b0, 1'b0, -1);
        run_frame(8'h45, 8'h00, 8'hFF, 0, 1'b0, 1'b0, -1);
        run_frame(8'h46, 8'h00, 8'd16, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_frame();
        run_frame(8'h55, 8'h02, 8'd8, 0, 1'b0, 1'b0, 7);
        run_frame(8'h56, 8'h00, 8'd3, 2, 1'b0, 1'b0, -1);
    endtask

    task automatic test_busy_writes();
        run_frame(8'h60, 8'h00, 8'd16, 2, 1'b0, 1'b1, -1);
        run_frame(8'h61, 8'h00, 8'd16, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_frame(8'h70, 8'h00, 8'd4, 0, 1'b1, 1'b0, -1);
        for (int i = 0; i < 10; i++)
            run_frame(8'($urandom), 8'($urandom), 8'($urandom_range(0, 24)),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_payload();
        test_backpressure();
        test_sum_wrap();
        test_len_clamp();
        test_reset_mid_frame();
        test_busy_writes();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
